// File: rtl/core_pkg.sv
// Shared types for the retirement stage: commit FSM states, trap causes and the per-slot ROB view.
// Pure declarations; no logic, no timing.
package core_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int AREG_W    = 5;
    localparam int CAUSE_W   = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } commit_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_FETCH_MISALIGN = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_FETCH_FAULT    = 5'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR  = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT     = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_FAULT     = 5'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_FAULT    = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL          = 5'd11;

    // Width-independent per-slot ROB fields; PCs and tags stay on their own ports.
    typedef struct packed {
        logic               valid;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
        logic               is_store;
        logic               is_branch;
        logic               mispred;
        logic               br_taken;
        logic [AREG_W-1:0]  arch_rd;
    } commit_slot_t;

endpackage

// File: rtl/commit_select.sv
// Combinational in-order prefix scan of the ROB head slots with store/branch port limits.
// Zero latency; an unready LSU truncates the prefix at the first store.
module commit_select
    import core_pkg::*;
#(
    parameter int COMMIT_W = 4,
    parameter int MAX_ST   = 1,
    parameter int BP_PORTS = 1,
    parameter int SLOT_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1,
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  logic                i_en,
    input  commit_slot_t        i_slot [COMMIT_W],
    input  logic                i_lsu_store_ready,
    output logic [COMMIT_W-1:0] o_retire_mask,
    output logic [CNT_W-1:0]    o_retire_cnt,
    output logic                o_exc_vld,
    output logic [SLOT_W-1:0]   o_exc_slot,
    output logic                o_mispred_vld,
    output logic [SLOT_W-1:0]   o_mispred_slot,
    output logic [MAX_ST-1:0]   o_st_lane_vld,
    output logic [SLOT_W-1:0]   o_st_lane_slot [MAX_ST],
    output logic [BP_PORTS-1:0] o_br_lane_vld,
    output logic [SLOT_W-1:0]   o_br_lane_slot [BP_PORTS],
    output logic                o_stall_lsu
);

    logic w_unused_fields;

    always_comb begin
        w_unused_fields = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_unused_fields = w_unused_fields ^ (^i_slot[i].cause) ^ i_slot[i].br_taken ^ (^i_slot[i].arch_rd);
        end
    end

    always_comb begin
        int   w_st_cnt;
        int   w_br_cnt;
        logic w_stop;

        o_retire_mask  = '0;
        o_retire_cnt   = '0;
        o_exc_vld      = 1'b0;
        o_exc_slot     = '0;
        o_mispred_vld  = 1'b0;
        o_mispred_slot = '0;
        o_st_lane_vld  = '0;
        o_br_lane_vld  = '0;
        o_stall_lsu    = 1'b0;
        for (int k = 0; k < MAX_ST; k++) o_st_lane_slot[k] = '0;
        for (int k = 0; k < BP_PORTS; k++) o_br_lane_slot[k] = '0;
        w_st_cnt = 0;
        w_br_cnt = 0;
        w_stop   = !i_en;

        for (int i = 0; i < COMMIT_W; i++) begin
            if (!w_stop) begin
                if (!i_slot[i].valid) begin
                    w_stop = 1'b1;
                end else if (i_slot[i].exc) begin
                    // The faulting slot is popped but has no architectural effect.
                    o_retire_mask[i] = 1'b1;
                    o_retire_cnt     = o_retire_cnt + CNT_W'(1);
                    o_exc_vld        = 1'b1;
                    o_exc_slot       = SLOT_W'(i);
                    w_stop           = 1'b1;
                end else if (i_slot[i].is_store && (w_st_cnt >= MAX_ST || !i_lsu_store_ready)) begin
                    w_stop      = 1'b1;
                    o_stall_lsu = (w_st_cnt < MAX_ST);
                end else if (i_slot[i].is_branch && w_br_cnt >= BP_PORTS) begin
                    w_stop = 1'b1;
                end else begin
                    o_retire_mask[i] = 1'b1;
                    o_retire_cnt     = o_retire_cnt + CNT_W'(1);
                    if (i_slot[i].is_store) begin
                        for (int k = 0; k < MAX_ST; k++) begin
                            if (k == w_st_cnt) begin
                                o_st_lane_vld[k]  = 1'b1;
                                o_st_lane_slot[k] = SLOT_W'(i);
                            end
                        end
                        w_st_cnt = w_st_cnt + 1;
                    end
                    if (i_slot[i].is_branch) begin
                        for (int k = 0; k < BP_PORTS; k++) begin
                            if (k == w_br_cnt) begin
                                o_br_lane_vld[k]  = 1'b1;
                                o_br_lane_slot[k] = SLOT_W'(i);
                            end
                        end
                        w_br_cnt = w_br_cnt + 1;
                        if (i_slot[i].mispred) begin
                            o_mispred_vld  = 1'b1;
                            o_mispred_slot = SLOT_W'(i);
                            w_stop         = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_unit_v2.sv
// In-order retirement: ARF/free-list/committed-RAT update, store and predictor commit, flush/recover FSM.
// Retire count is combinational, side effects one cycle later; LSU not-ready blocks the first store and younger slots.
module commit_unit_v2
    import core_pkg::*;
#(
    parameter int COMMIT_W  = 4,
    parameter int XLEN      = 32,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_W    = 6,
    parameter int ROB_IDX_W = core_pkg::ROB_IDX_W,
    parameter int MAX_ST    = 1,
    parameter int BP_PORTS  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [COMMIT_W-1:0]          i_rob_valid,
    input  logic [ROB_IDX_W-1:0]         i_rob_head_idx,
    input  logic [AREG_W-1:0]            i_rob_arch_rd     [COMMIT_W],
    input  logic [PHYS_W-1:0]            i_rob_phys_rd     [COMMIT_W],
    input  logic [COMMIT_W-1:0]          i_rob_exc,
    input  logic [CAUSE_W-1:0]           i_rob_cause       [COMMIT_W],
    input  logic [COMMIT_W-1:0]          i_rob_is_store,
    input  logic [COMMIT_W-1:0]          i_rob_is_branch,
    input  logic [COMMIT_W-1:0]          i_rob_mispred,
    input  logic [COMMIT_W-1:0]          i_rob_br_taken,
    input  logic [XLEN-1:0]              i_rob_pc          [COMMIT_W],
    input  logic [XLEN-1:0]              i_rob_br_target   [COMMIT_W],
    input  logic                         i_rob_empty,
    output logic [$clog2(COMMIT_W+1)-1:0] o_rob_retire_cnt,
    output logic [PHYS_W-1:0]            o_prf_rtag        [COMMIT_W],
    input  logic [XLEN-1:0]              i_prf_rdata       [COMMIT_W],
    output logic [COMMIT_W-1:0]          o_arf_wen,
    output logic [AREG_W-1:0]            o_arf_waddr       [COMMIT_W],
    output logic [XLEN-1:0]              o_arf_wdata       [COMMIT_W],
    output logic [COMMIT_W-1:0]          o_free_en,
    output logic [PHYS_W-1:0]            o_free_phys       [COMMIT_W],
    input  logic                         i_lsu_store_ready,
    output logic [MAX_ST-1:0]            o_lsu_commit_en,
    output logic [ROB_IDX_W-1:0]         o_lsu_commit_rob_idx [MAX_ST],
    output logic [BP_PORTS-1:0]          o_bp_upd_en,
    output logic [XLEN-1:0]              o_bp_upd_pc       [BP_PORTS],
    output logic [XLEN-1:0]              o_bp_upd_target   [BP_PORTS],
    output logic [BP_PORTS-1:0]          o_bp_upd_taken,
    input  logic [XLEN-1:0]              i_trap_vec,
    output logic                         o_exception_valid,
    output logic [CAUSE_W-1:0]           o_exception_cause,
    output logic [XLEN-1:0]              o_exception_pc,
    output logic                         o_flush_pipeline,
    output logic [XLEN-1:0]              o_flush_pc,
    output logic                         o_rat_restore_en,
    output logic [PHYS_W-1:0]            o_crat_tag        [ARCH_REGS],
    output logic [63:0]                  o_perf_retired,
    output logic [63:0]                  o_perf_flushes,
    output logic [63:0]                  o_perf_stall_lsu
);

    localparam int SLOT_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
    localparam int CNT_W  = $clog2(COMMIT_W + 1);

    commit_state_e         r_state, w_state_nxt;
    commit_slot_t          w_slot [COMMIT_W];

    logic [COMMIT_W-1:0]   w_retire_mask;
    logic [CNT_W-1:0]      w_retire_cnt;
    logic                  w_exc_vld, w_mispred_vld, w_stall_lsu, w_take_flush;
    logic [SLOT_W-1:0]     w_exc_slot, w_mispred_slot;
    logic [MAX_ST-1:0]     w_st_lane_vld;
    logic [SLOT_W-1:0]     w_st_lane_slot [MAX_ST];
    logic [BP_PORTS-1:0]   w_br_lane_vld;
    logic [SLOT_W-1:0]     w_br_lane_slot [BP_PORTS];

    logic [COMMIT_W-1:0]   w_wen;
    logic [PHYS_W-1:0]     w_prev [COMMIT_W];
    logic [PHYS_W-1:0]     w_crat_nxt [ARCH_REGS];

    logic [PHYS_W-1:0]     r_crat [ARCH_REGS];
    logic [COMMIT_W-1:0]   r_arf_wen, r_free_en;
    logic [AREG_W-1:0]     r_arf_waddr [COMMIT_W];
    logic [XLEN-1:0]       r_arf_wdata [COMMIT_W];
    logic [PHYS_W-1:0]     r_free_phys [COMMIT_W];
    logic [MAX_ST-1:0]     r_lsu_commit_en;
    logic [ROB_IDX_W-1:0]  r_lsu_commit_rob_idx [MAX_ST];
    logic [BP_PORTS-1:0]   r_bp_upd_en, r_bp_upd_taken;
    logic [XLEN-1:0]       r_bp_upd_pc [BP_PORTS];
    logic [XLEN-1:0]       r_bp_upd_target [BP_PORTS];
    logic                  r_exception_valid, r_flush_pipeline, r_rat_restore_en;
    logic [CAUSE_W-1:0]    r_exception_cause;
    logic [XLEN-1:0]       r_exception_pc, r_flush_pc;
    logic [63:0]           r_perf_retired, r_perf_flushes, r_perf_stall_lsu;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            w_slot[i].valid     = i_rob_valid[i];
            w_slot[i].exc       = i_rob_exc[i];
            w_slot[i].cause     = i_rob_cause[i];
            w_slot[i].is_store  = i_rob_is_store[i];
            w_slot[i].is_branch = i_rob_is_branch[i];
            w_slot[i].mispred   = i_rob_mispred[i];
            w_slot[i].br_taken  = i_rob_br_taken[i];
            w_slot[i].arch_rd   = i_rob_arch_rd[i];
        end
    end

    commit_select #(
        .COMMIT_W (COMMIT_W),
        .MAX_ST   (MAX_ST),
        .BP_PORTS (BP_PORTS),
        .SLOT_W   (SLOT_W),
        .CNT_W    (CNT_W)
    ) u_select (
        .i_en              (r_state == ST_RUN),
        .i_slot            (w_slot),
        .i_lsu_store_ready (i_lsu_store_ready),
        .o_retire_mask     (w_retire_mask),
        .o_retire_cnt      (w_retire_cnt),
        .o_exc_vld         (w_exc_vld),
        .o_exc_slot        (w_exc_slot),
        .o_mispred_vld     (w_mispred_vld),
        .o_mispred_slot    (w_mispred_slot),
        .o_st_lane_vld     (w_st_lane_vld),
        .o_st_lane_slot    (w_st_lane_slot),
        .o_br_lane_vld     (w_br_lane_vld),
        .o_br_lane_slot    (w_br_lane_slot),
        .o_stall_lsu       (w_stall_lsu)
    );

    assign w_take_flush = w_exc_vld | w_mispred_vld;

    // Previous mapping chains through older same-group writers; ascending order lets the youngest win.
    always_comb begin
        w_crat_nxt = r_crat;
        for (int j = 0; j < COMMIT_W; j++) begin
            w_wen[j]  = w_retire_mask[j] & ~i_rob_exc[j] & (i_rob_arch_rd[j] != '0);
            w_prev[j] = r_crat[i_rob_arch_rd[j]];
            for (int k = 0; k < COMMIT_W; k++) begin
                if (k < j && w_wen[k] && i_rob_arch_rd[k] == i_rob_arch_rd[j]) begin
                    w_prev[j] = i_rob_phys_rd[k];
                end
            end
            if (w_wen[j]) begin
                w_crat_nxt[i_rob_arch_rd[j]] = i_rob_phys_rd[j];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (w_take_flush) w_state_nxt = ST_FLUSH;
            ST_FLUSH:   w_state_nxt = ST_RECOVER;
            ST_RECOVER: if (i_rob_empty) w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state           <= ST_RUN;
            for (int r = 0; r < ARCH_REGS; r++) r_crat[r] <= PHYS_W'(r);
            r_arf_wen         <= '0;
            r_free_en         <= '0;
            for (int i = 0; i < COMMIT_W; i++) begin
                r_arf_waddr[i] <= '0;
                r_arf_wdata[i] <= '0;
                r_free_phys[i] <= '0;
            end
            r_lsu_commit_en   <= '0;
            for (int k = 0; k < MAX_ST; k++) r_lsu_commit_rob_idx[k] <= '0;
            r_bp_upd_en       <= '0;
            r_bp_upd_taken    <= '0;
            for (int k = 0; k < BP_PORTS; k++) begin
                r_bp_upd_pc[k]     <= '0;
                r_bp_upd_target[k] <= '0;
            end
            r_exception_valid <= 1'b0;
            r_exception_cause <= '0;
            r_exception_pc    <= '0;
            r_flush_pipeline  <= 1'b0;
            r_flush_pc        <= '0;
            r_rat_restore_en  <= 1'b0;
            r_perf_retired    <= '0;
            r_perf_flushes    <= '0;
            r_perf_stall_lsu  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_crat    <= w_crat_nxt;
            r_arf_wen <= w_wen;
            r_free_en <= w_wen;
            for (int i = 0; i < COMMIT_W; i++) begin
                r_arf_waddr[i] <= w_wen[i] ? i_rob_arch_rd[i] : '0;
                r_arf_wdata[i] <= w_wen[i] ? i_prf_rdata[i]   : '0;
                r_free_phys[i] <= w_wen[i] ? w_prev[i]        : '0;
            end
            r_lsu_commit_en <= w_st_lane_vld;
            for (int k = 0; k < MAX_ST; k++) begin
                r_lsu_commit_rob_idx[k] <= w_st_lane_vld[k] ?
                    i_rob_head_idx + ROB_IDX_W'(w_st_lane_slot[k]) : '0;
            end
            r_bp_upd_en <= w_br_lane_vld;
            for (int k = 0; k < BP_PORTS; k++) begin
                r_bp_upd_taken[k]  <= w_br_lane_vld[k] & i_rob_br_taken[w_br_lane_slot[k]];
                r_bp_upd_pc[k]     <= w_br_lane_vld[k] ? i_rob_pc[w_br_lane_slot[k]]        : '0;
                r_bp_upd_target[k] <= w_br_lane_vld[k] ? i_rob_br_target[w_br_lane_slot[k]] : '0;
            end
            r_flush_pipeline  <= w_take_flush;
            r_exception_valid <= w_exc_vld;
            r_exception_cause <= w_exc_vld ? i_rob_cause[w_exc_slot] : '0;
            r_exception_pc    <= w_exc_vld ? i_rob_pc[w_exc_slot]    : '0;
            r_flush_pc        <= w_exc_vld     ? i_trap_vec :
                                 w_mispred_vld ? i_rob_br_target[w_mispred_slot] : '0;
            r_rat_restore_en  <= (r_state == ST_FLUSH);
            r_perf_retired    <= r_perf_retired + 64'(w_retire_cnt) - 64'(w_exc_vld);
            r_perf_flushes    <= r_perf_flushes + 64'(w_take_flush);
            r_perf_stall_lsu  <= r_perf_stall_lsu + 64'(w_stall_lsu);
        end
    end

    assign o_rob_retire_cnt     = w_retire_cnt;
    assign o_prf_rtag           = i_rob_phys_rd;
    assign o_arf_wen            = r_arf_wen;
    assign o_arf_waddr          = r_arf_waddr;
    assign o_arf_wdata          = r_arf_wdata;
    assign o_free_en            = r_free_en;
    assign o_free_phys          = r_free_phys;
    assign o_lsu_commit_en      = r_lsu_commit_en;
    assign o_lsu_commit_rob_idx = r_lsu_commit_rob_idx;
    assign o_bp_upd_en          = r_bp_upd_en;
    assign o_bp_upd_pc          = r_bp_upd_pc;
    assign o_bp_upd_target      = r_bp_upd_target;
    assign o_bp_upd_taken       = r_bp_upd_taken;
    assign o_exception_valid    = r_exception_valid;
    assign o_exception_cause    = r_exception_cause;
    assign o_exception_pc       = r_exception_pc;
    assign o_flush_pipeline     = r_flush_pipeline;
    assign o_flush_pc           = r_flush_pc;
    assign o_rat_restore_en     = r_rat_restore_en;
    assign o_crat_tag           = r_crat;
    assign o_perf_retired       = r_perf_retired;
    assign o_perf_flushes       = r_perf_flushes;
    assign o_perf_stall_lsu     = r_perf_stall_lsu;

endmodule

// File: tb/tb_commit_unit_v2.sv
// Directed bench for commit_unit_v2 with hand-computed expectations at default parameters.
module tb_commit_unit_v2;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rob_valid;
    logic [4:0]  rob_head_idx;
    logic [4:0]  rob_arch_rd [4];
    logic [5:0]  rob_phys_rd [4];
    logic [3:0]  rob_exc, rob_is_store, rob_is_branch, rob_mispred, rob_br_taken;
    logic [4:0]  rob_cause [4];
    logic [31:0] rob_pc [4];
    logic [31:0] rob_br_target [4];
    logic        rob_empty;
    logic [2:0]  retire_cnt;
    logic [5:0]  prf_rtag [4];
    logic [31:0] prf_rdata [4];
    logic [3:0]  arf_wen, free_en;
    logic [4:0]  arf_waddr [4];
    logic [31:0] arf_wdata [4];
    logic [5:0]  free_phys [4];
    logic        lsu_store_ready;
    logic [0:0]  lsu_commit_en;
    logic [4:0]  lsu_commit_rob_idx [1];
    logic [0:0]  bp_upd_en, bp_upd_taken;
    logic [31:0] bp_upd_pc [1];
    logic [31:0] bp_upd_target [1];
    logic [31:0] trap_vec;
    logic        exception_valid, flush_pipeline, rat_restore_en;
    logic [4:0]  exception_cause;
    logic [31:0] exception_pc, flush_pc;
    logic [5:0]  crat_tag [32];
    logic [63:0] perf_retired, perf_flushes, perf_stall_lsu;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // PRF stand-in: data is a fixed function of the tag being read.
    always_comb begin
        for (int i = 0; i < 4; i++) prf_rdata[i] = 32'hA000_0000 | {26'd0, prf_rtag[i]};
    end

    commit_unit_v2 dut (
        .i_clk(clk), .i_reset(reset),
        .i_rob_valid(rob_valid), .i_rob_head_idx(rob_head_idx),
        .i_rob_arch_rd(rob_arch_rd), .i_rob_phys_rd(rob_phys_rd),
        .i_rob_exc(rob_exc), .i_rob_cause(rob_cause),
        .i_rob_is_store(rob_is_store), .i_rob_is_branch(rob_is_branch),
        .i_rob_mispred(rob_mispred), .i_rob_br_taken(rob_br_taken),
        .i_rob_pc(rob_pc), .i_rob_br_target(rob_br_target),
        .i_rob_empty(rob_empty), .o_rob_retire_cnt(retire_cnt),
        .o_prf_rtag(prf_rtag), .i_prf_rdata(prf_rdata),
        .o_arf_wen(arf_wen), .o_arf_waddr(arf_waddr), .o_arf_wdata(arf_wdata),
        .o_free_en(free_en), .o_free_phys(free_phys),
        .i_lsu_store_ready(lsu_store_ready),
        .o_lsu_commit_en(lsu_commit_en), .o_lsu_commit_rob_idx(lsu_commit_rob_idx),
        .o_bp_upd_en(bp_upd_en), .o_bp_upd_pc(bp_upd_pc),
        .o_bp_upd_target(bp_upd_target), .o_bp_upd_taken(bp_upd_taken),
        .i_trap_vec(trap_vec),
        .o_exception_valid(exception_valid), .o_exception_cause(exception_cause),
        .o_exception_pc(exception_pc),
        .o_flush_pipeline(flush_pipeline), .o_flush_pc(flush_pc),
        .o_rat_restore_en(rat_restore_en), .o_crat_tag(crat_tag),
        .o_perf_retired(perf_retired), .o_perf_flushes(perf_flushes),
        .o_perf_stall_lsu(perf_stall_lsu)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_slots();
        rob_valid = '0; rob_exc = '0; rob_is_store = '0; rob_is_branch = '0;
        rob_mispred = '0; rob_br_taken = '0;
        for (int i = 0; i < 4; i++) begin
            rob_arch_rd[i] = '0; rob_phys_rd[i] = '0; rob_cause[i] = '0;
            rob_pc[i] = '0; rob_br_target[i] = '0;
        end
    endtask

    // flags = {exc, store, branch, mispred, taken}
    task automatic slot(input int i, input logic [4:0] rd, input logic [5:0] tag,
                        input logic [4:0] flags, input logic [4:0] cause,
                        input logic [31:0] pc, input logic [31:0] tgt);
        rob_valid[i]     = 1'b1;
        rob_arch_rd[i]   = rd;
        rob_phys_rd[i]   = tag;
        rob_exc[i]       = flags[4];
        rob_is_store[i]  = flags[3];
        rob_is_branch[i] = flags[2];
        rob_mispred[i]   = flags[1];
        rob_br_taken[i]  = flags[0];
        rob_cause[i]     = cause;
        rob_pc[i]        = pc;
        rob_br_target[i] = tgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rob_head_idx = '0; rob_empty = 1'b0;
        lsu_store_ready = 1'b1; trap_vec = 32'h100;
        clear_slots();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_retire_cnt", 64'(retire_cnt), 0);
        check("rst_arf_wen", 64'(arf_wen), 0);
        check("rst_crat5", 64'(crat_tag[5]), 5);
        check("rst_perf_retired", perf_retired, 0);
        check("rst_flush", 64'(flush_pipeline), 0);

        // Four ALU ops to x1..x4
        for (int i = 0; i < 4; i++) slot(i, 5'(i + 1), 6'(40 + i), 5'b00000, 0, 0, 0);
        #1 check("alu4_cnt", 64'(retire_cnt), 4);
        tick(); clear_slots();
        check("alu4_wen", 64'(arf_wen), 64'hF);
        for (int i = 0; i < 4; i++) check("alu4_free", 64'(free_phys[i]), 64'(i + 1));
        check("alu4_crat1", 64'(crat_tag[1]), 40);
        check("alu4_waddr3", 64'(arf_waddr[3]), 4);
        check("alu4_wdata2", 64'(arf_wdata[2]), 64'hA000_002A);
        check("alu4_perf", perf_retired, 4);

        // Same-group rename chain on x5
        slot(0, 5, 50, 5'b00000, 0, 0, 0);
        slot(1, 6, 51, 5'b00000, 0, 0, 0);
        slot(2, 5, 52, 5'b00000, 0, 0, 0);
        #1 check("chain_cnt", 64'(retire_cnt), 3);
        tick(); clear_slots();
        check("chain_wen", 64'(arf_wen), 64'b0111);
        check("chain_free0", 64'(free_phys[0]), 5);
        check("chain_free1", 64'(free_phys[1]), 6);
        check("chain_free2", 64'(free_phys[2]), 50);
        check("chain_crat5", 64'(crat_tag[5]), 52);

        // Two stores, one store port
        rob_head_idx = 8;
        slot(0, 7, 20, 5'b00000, 0, 0, 0);
        slot(1, 0, 0, 5'b01000, 0, 0, 0);
        slot(2, 8, 21, 5'b00000, 0, 0, 0);
        slot(3, 0, 0, 5'b01000, 0, 0, 0);
        #1 check("st2_cnt", 64'(retire_cnt), 3);
        tick(); clear_slots();
        check("st2_lsu_en", 64'(lsu_commit_en), 1);
        check("st2_lsu_idx", 64'(lsu_commit_rob_idx[0]), 9);
        check("st2_wen", 64'(arf_wen), 64'b0101);
        rob_head_idx = 11;
        slot(0, 0, 0, 5'b01000, 0, 0, 0);
        #1 check("st2b_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots();
        check("st2b_lsu_idx", 64'(lsu_commit_rob_idx[0]), 11);
        check("st2b_perf", perf_retired, 11);

        // LSU not ready
        rob_head_idx = 12; lsu_store_ready = 1'b0;
        slot(0, 9, 22, 5'b00000, 0, 0, 0);
        slot(1, 0, 0, 5'b01000, 0, 0, 0);
        slot(2, 10, 23, 5'b00000, 0, 0, 0);
        #1 check("lsu_blk_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots(); lsu_store_ready = 1'b1;
        check("lsu_blk_stall", perf_stall_lsu, 1);
        check("lsu_blk_en", 64'(lsu_commit_en), 0);
        check("lsu_blk_wen", 64'(arf_wen), 1);

        // Valid gaps
        slot(1, 11, 23, 5'b00000, 0, 0, 0);
        #1 check("gap_slot0_cnt", 64'(retire_cnt), 0);
        slot(0, 11, 24, 5'b00000, 0, 0, 0);
        rob_valid[1] = 1'b0;
        slot(2, 12, 25, 5'b00000, 0, 0, 0);
        #1 check("gap_slot1_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots();
        check("gap_crat11", 64'(crat_tag[11]), 24);
        check("gap_crat12", 64'(crat_tag[12]), 12);

        // Two branches, one predictor port
        slot(0, 0, 0, 5'b00101, 0, 32'h300, 32'h340);
        slot(1, 0, 0, 5'b00100, 0, 32'h310, 32'h380);
        #1 check("br2_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots();
        check("br2_bp_en", 64'(bp_upd_en), 1);
        check("br2_bp_pc", 64'(bp_upd_pc[0]), 64'h300);
        check("br2_bp_tgt", 64'(bp_upd_target[0]), 64'h340);
        check("br2_bp_taken", 64'(bp_upd_taken), 1);
        check("br2_perf", perf_retired, 14);

        // Exception in slot 2
        slot(0, 12, 26, 5'b00000, 0, 0, 0);
        slot(1, 13, 27, 5'b00000, 0, 0, 0);
        slot(2, 14, 28, 5'b10000, CAUSE_BREAKPOINT, 32'h200, 0);
        slot(3, 15, 29, 5'b00000, 0, 0, 0);
        #1 check("exc_cnt", 64'(retire_cnt), 3);
        tick();
        check("exc_flush", 64'(flush_pipeline), 1);
        check("exc_valid", 64'(exception_valid), 1);
        check("exc_cause", 64'(exception_cause), 3);
        check("exc_pc", 64'(exception_pc), 64'h200);
        check("exc_flush_pc", 64'(flush_pc), 64'h100);
        check("exc_wen", 64'(arf_wen), 64'b0011);
        check("exc_crat13", 64'(crat_tag[13]), 27);
        check("exc_crat14", 64'(crat_tag[14]), 14);
        check("exc_flushes", perf_flushes, 1);
        check("exc_perf", perf_retired, 16);
        check("exc_restore_early", 64'(rat_restore_en), 0);
        check("exc_flush_cnt", 64'(retire_cnt), 0);
        tick();
        check("exc_restore", 64'(rat_restore_en), 1);
        check("exc_flush_pulse", 64'(flush_pipeline), 0);
        check("exc_rec_cnt", 64'(retire_cnt), 0);
        tick();
        check("exc_restore_once", 64'(rat_restore_en), 0);
        check("exc_wait_cnt", 64'(retire_cnt), 0);
        clear_slots(); rob_empty = 1'b1;
        tick(); rob_empty = 1'b0;

        // Mispredict in slot 1
        slot(0, 16, 30, 5'b00000, 0, 0, 0);
        slot(1, 17, 31, 5'b00111, 0, 32'h480, 32'h4C0);
        slot(2, 18, 32, 5'b00000, 0, 0, 0);
        #1 check("mp_cnt", 64'(retire_cnt), 2);
        tick(); clear_slots(); rob_empty = 1'b1;
        check("mp_flush", 64'(flush_pipeline), 1);
        check("mp_exc_valid", 64'(exception_valid), 0);
        check("mp_flush_pc", 64'(flush_pc), 64'h4C0);
        check("mp_wen", 64'(arf_wen), 64'b0011);
        check("mp_bp_pc", 64'(bp_upd_pc[0]), 64'h480);
        check("mp_crat17", 64'(crat_tag[17]), 31);
        check("mp_crat18", 64'(crat_tag[18]), 18);
        check("mp_flushes", perf_flushes, 2);
        tick();
        check("mp_restore", 64'(rat_restore_en), 1);
        tick(); rob_empty = 1'b0;

        // ROB index wrap
        rob_head_idx = 30;
        slot(0, 19, 33, 5'b00000, 0, 0, 0);
        slot(1, 20, 34, 5'b00000, 0, 0, 0);
        slot(2, 21, 35, 5'b00000, 0, 0, 0);
        slot(3, 0, 0, 5'b01000, 0, 0, 0);
        #1 check("wrap_cnt", 64'(retire_cnt), 4);
        tick(); clear_slots();
        check("wrap_lsu_idx", 64'(lsu_commit_rob_idx[0]), 1);
        check("wrap_perf", perf_retired, 22);

        // Reset during RECOVER
        slot(0, 1, 9, 5'b10000, CAUSE_ILLEGAL_INSTR, 32'h500, 0);
        #1 check("rr_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots();
        check("rr_flush", 64'(flush_pipeline), 1);
        tick();
        check("rr_restore", 64'(rat_restore_en), 1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        check("rr_restore_clr", 64'(rat_restore_en), 0);
        check("rr_flush_clr", 64'(flush_pipeline), 0);
        check("rr_crat17", 64'(crat_tag[17]), 17);
        check("rr_perf", perf_retired, 0);
        check("rr_flushes", perf_flushes, 0);
        check("rr_stall", perf_stall_lsu, 0);
        check("rr_lsu_en", 64'(lsu_commit_en), 0);
        slot(0, 1, 5, 5'b00000, 0, 0, 0);
        #1 check("rr_run_cnt", 64'(retire_cnt), 1);
        tick(); clear_slots();
        check("rr_no_flush", 64'(flush_pipeline), 0);
        check("rr_free0", 64'(free_phys[0]), 1);
        check("rr_crat1", 64'(crat_tag[1]), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
